// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO drained by a start/data/stop serialiser.
// Line is LSB first at CLK_FREQ/BAUD_RATE clocks per bit (integer truncation).
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          tx_out
);

  localparam int unsigned TICKS = CLK_FREQ / BAUD_RATE;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned TW    = (TICKS > 1) ? $clog2(TICKS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [TW-1:0]   tick;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_c;
  logic            pop_c;
  logic            tick_end_c;
  logic [CW-1:0]   next_count_c;

  assign tick_end_c   = (tick == TW'(TICKS - 1));
  assign push_c       = wr_en && !full;
  // Pop from IDLE, or at the end of a stop bit so the next frame follows with no gap.
  assign pop_c        = (fifo_count != '0) &&
                        ((state == IDLE) || ((state == STOP) && tick_end_c));
  assign next_count_c = fifo_count + CW'(push_c) - CW'(pop_c);

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= next_count_c;
      full       <= (next_count_c == CW'(FIFO_DEPTH));
      overflow   <= wr_en && full;
    end
  end

  // Transmit FSM with registered line and busy outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          if (pop_c) begin
            shift  <= mem[rd_ptr];
            tx_out <= 1'b0;
            busy   <= 1'b1;
            tick   <= '0;
            state  <= START;
          end
        end
        START: begin
          if (tick_end_c) begin
            tick    <= '0;
            tx_out  <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        DATA: begin
          if (tick_end_c) begin
            tick <= '0;
            if (bit_idx == 3'd7) begin
              tx_out <= 1'b1;
              state  <= STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx_out  <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        STOP: begin
          if (tick_end_c) begin
            tick <= '0;
            if (pop_c) begin
              shift  <= mem[rd_ptr];
              tx_out <= 1'b0;
              state  <= START;
            end else begin
              tx_out <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
